// File: rtl/sw_debounce.sv
// Multi-channel switch synchronizer and debouncer: 2-flop sync, per-channel
// stability counter, registered level plus one-cycle rise/fall pulses.
module sw_debounce #(
  parameter int WIDTH         = 2,
  parameter int STABLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] upd;

  // A channel updates once its synchronized level has disagreed for the full window.
  always_comb begin
    upd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      upd[i] = (s2[i] != sw_out[i]) && (cnt[i] == TERM);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      sw_out  <= '0;
      sw_rise <= '0;
      sw_fall <= '0;
      changed <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1      <= sw_in;
      s2      <= s1;
      sw_out  <= sw_out ^ upd;
      sw_rise <= upd & s2;
      sw_fall <= upd & ~s2;
      changed <= |upd;
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == sw_out[i] || upd[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce: directed scenarios followed by random
// bouncy stimulus, checked against a run-length reference model.
module tb_sw_debounce;

  localparam int W  = 2;
  localparam int SC = 4;
  localparam int EW = 3 * W + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw_in = '0;
  logic [W-1:0] sw_out, sw_rise, sw_fall;
  logic         changed;

  sw_debounce #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
    .clk     (clk),
    .rst     (rst),
    .sw_in   (sw_in),
    .sw_out  (sw_out),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall),
    .changed (changed)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rise0_cnt   = 0;
  int first_rise0 = 0;

  logic [EW-1:0] exp_q[$];

  // Reference model: a level is accepted after SC consecutive mismatching
  // samples, where samples are the inputs seen two edges earlier.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_out;
  int           m_run[W];

  task automatic model(input logic r, input logic [W-1:0] v);
    logic [W-1:0] d, rise, fall;
    rise = '0;
    fall = '0;
    if (r) begin
      hist = '{'0, '0};
      m_out = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      d = hist.pop_front();
      hist.push_back(v);
      for (int i = 0; i < W; i++) begin
        if (d[i] != m_out[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == SC) begin
            m_out[i] = d[i];
            rise[i]  = d[i];
            fall[i]  = ~d[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    exp_q.push_back({m_out, rise, fall, |(rise | fall)});
  endtask

  task automatic drive(input logic r, input logic [W-1:0] v);
    @(negedge clk);
    rst   = r;
    sw_in = v;
    model(r, v);
  endtask

  task automatic hold(input logic [W-1:0] v, input int n);
    for (int k = 0; k < n; k++) drive(1'b0, v);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : monitor
    logic [EW-1:0] e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {sw_out, sw_rise, sw_fall, changed};
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL scoreboard cyc=%0d out/rise/fall/chg got=%b_%b_%b_%b want=%b_%b_%b_%b",
                   cyc, got[EW-1 -: W], got[2*W -: W], got[W -: W], got[0],
                   e[EW-1 -: W], e[2*W -: W], e[W -: W], e[0]);
        end
        if (sw_rise[0] === 1'b1) begin
          rise0_cnt++;
          if (first_rise0 == 0) first_rise0 = cyc;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int step_edge;
    int hold_cnt[W];
    logic [W-1:0] v;

    hist  = '{'0, '0};
    m_out = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;

    // reset held with inputs high: outputs must read zero throughout
    for (int k = 0; k < 3; k++) drive(1'b1, 2'b11);
    drive(1'b1, 2'b00);
    hold(2'b00, 3);

    // clean step on channel 0
    first_rise0 = 0;
    drive(1'b0, 2'b01);
    step_edge = cyc + 1;
    hold(2'b01, SC + 4);
    settle();
    check("clean_step_latency", first_rise0 - step_edge, SC + 1);
    check("clean_step_out", int'(sw_out), 1);

    // glitch on channel 1, 3 cycles long
    hold(2'b11, SC - 1);
    hold(2'b01, 20);
    settle();
    check("glitch_out", int'(sw_out), 1);

    // return channel 0 to 0, then bounce and settle
    hold(2'b00, SC + 4);
    rise0_cnt   = 0;
    first_rise0 = 0;
    drive(1'b0, 2'b01);
    drive(1'b0, 2'b00);
    drive(1'b0, 2'b01);
    drive(1'b0, 2'b01);
    drive(1'b0, 2'b00);
    drive(1'b0, 2'b01);
    step_edge = cyc + 1;
    hold(2'b01, SC + 6);
    settle();
    check("bounce_rise_count", rise0_cnt, 1);
    check("bounce_latency", first_rise0 - step_edge, SC + 1);

    // both channels flip on the same edge
    hold(2'b10, SC + 4);
    settle();
    check("simul_out", int'(sw_out), 2);

    // reset in the middle of a count on channel 0
    hold(2'b00, SC + 4);
    hold(2'b01, SC - 1);
    drive(1'b1, 2'b01);
    first_rise0 = 0;
    drive(1'b0, 2'b01);
    step_edge = cyc + 1;
    hold(2'b01, SC + 4);
    settle();
    check("reset_midcount_latency", first_rise0 - step_edge, SC + 1);

    // random bouncy inputs with occasional resets
    v = '0;
    for (int i = 0; i < W; i++) hold_cnt[i] = 0;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < W; i++) begin
        if (hold_cnt[i] == 0) begin
          v[i] = ~v[i];
          hold_cnt[i] = $urandom_range(1, 2 * SC + 2);
        end
        hold_cnt[i]--;
      end
      drive($urandom_range(0, 149) == 0, v);
    end

    settle();
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Multi-channel switch synchronizer and debouncer that cleans raw board switch inputs before they reach the combinational logic in `top`. Bit 0 drives `top.a` and bit 1 drives `top.b`. Each channel passes through a 2-flop synchronizer and a per-channel stability counter. The block produces a registered debounced level plus single-cycle rise and fall pulses for downstream consumers such as trace markers and LED or event counters.

## Interface

Parameters:
- `WIDTH`, default 2: number of independent switch channels.
- `STABLE_CYCLES`, default 16: consecutive cycles a synchronized input must differ from `sw_out` before `sw_out` follows it. Legal range is ≥ 2. The counter width is `$clog2(STABLE_CYCLES)`.

Ports:
- `clk`  in  1  : single clock; all state updates on the rising edge.
- `rst`  in  1  : reset, synchronous and active-high.
- `sw_in`  in  WIDTH  : raw, asynchronous, bouncy switch levels.
- `sw_out`  out  WIDTH  : debounced level, registered.
- `sw_rise`  out  WIDTH  : 1-cycle pulse per bit on a debounced 0→1 change, registered.
- `sw_fall`  out  WIDTH  : 1-cycle pulse per bit on a debounced 1→0 change, registered.
- `changed`  out  1  : OR of all `sw_rise | sw_fall` bits, registered.

## Operation

- **Per-channel pipeline:** `s1 <= sw_in[i]`, then `s2 <= s1`. Only `s2` is used downstream of the synchronizer.
- **Counter `cnt[i]`:**
  - If `s2 == sw_out[i]`, set `cnt <= 0` (match state; any bounce back restarts the count).
  - If `s2 != sw_out[i]` and `cnt < STABLE_CYCLES-1`, set `cnt <= cnt+1`.
  - If `s2 != sw_out[i]` and `cnt == STABLE_CYCLES-1`, set `sw_out[i] <= s2` and `cnt <= 0`. On the same edge, `sw_rise[i] <= s2` and `sw_fall[i] <= ~s2`.
- **Pulse outputs:** `sw_rise` and `sw_fall` are 0 on every edge that is not an update edge. They never assert together for the same bit.
- **Channel independence:** channels are fully independent. Simultaneous updates on several bits are legal and produce pulses on all of those bits in the same cycle.
- **Counter range:** `cnt` never exceeds `STABLE_CYCLES-1`, so no wrap-around is possible.

## Timing

- **Reset values:** on any edge with `rst=1`, `s1`, `s2`, `cnt`, `sw_out`, `sw_rise`, `sw_fall` and `changed` all go to 0. This applies identically during operation: an in-progress count is discarded.
- **Latency:** take a clean step held on `sw_in[i]`, and call the first rising edge that samples it edge 1. `sw_out[i]`, the pulse and `changed` update on edge `STABLE_CYCLES+2`. For the default parameters that is edge 18.
- **Pulse width:** each pulse is high for exactly 1 cycle, starting at the edge where `sw_out` changes.
- **Glitch rejection:** a mismatch lasting ≤ `STABLE_CYCLES-1` cycles at `s2` never changes `sw_out`.
- **Edge case — return to match:** if `s2` returns to match on the edge that would have been the terminal count, `cnt` clears and no update occurs.
- **After reset release:** with `sw_in` held at 1, `sw_out` rises on edge `STABLE_CYCLES+2` after the first non-reset edge. Because the synchronizer was cleared, this behaves exactly like a step.
- **No combinational paths:** there is no combinational path from `sw_in` to any output.

## Test plan

- **Reset values:** hold `rst=1` for 3 cycles with `sw_in=2'b11`. Require every output to be 0 on each of those cycles.
- **Clean step, ch0:** `STABLE_CYCLES=4`, `sw_in=2'b00`, then step to `2'b01`. Require `sw_out=2'b01`, `sw_rise=2'b01` and `changed=1` on edge 6 only. Require `sw_rise` to read 0 on edge 7.
- **Glitch rejection:** `STABLE_CYCLES=4`, pulse `sw_in[1]` high for 3 cycles, then low. Require `sw_out` to stay `2'b00` and `changed` to stay 0 for 20 cycles.
- **Bounce then settle:** drive `sw_in[0]` as 1,0,1,1,0 over 5 cycles, then hold 1. Require `sw_out[0]` to rise exactly `STABLE_CYCLES+2` edges after the final 0→1. Require exactly one `sw_rise[0]` pulse over the whole sequence.
- **Simultaneous channels:** with `sw_out=2'b01`, change `sw_in` to `2'b10` on a single edge. Require `sw_fall=2'b01`, `sw_rise=2'b10` and `changed=1` on the same cycle, followed by `sw_out=2'b10`.
- **Reset mid-count:** step `sw_in[0]` to 1, then assert `rst` for 1 cycle on edge `STABLE_CYCLES`. Require `sw_out[0]` to stay 0 until `STABLE_CYCLES+2` edges after reset release.
